// File: rtl/march_cm_bist.sv
// March C- built-in self test for a synchronous single-port SRAM.
// One memory operation per cycle; read data is checked one cycle after the read.
module march_cm_bist #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 4,
    parameter int CNT_W        = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWrData,
    output logic              MemWe,
    output logic              MemRe,
    input  logic [DATA_W-1:0] MemRdData,
    output logic              Busy,
    output logic              Done,
    output logic              GoNoGo,
    output logic [ADDR_W-1:0] FailAddr,
    output logic [CNT_W-1:0]  FailCount
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [DATA_W-1:0] DATA_ONES = '1;
    localparam logic [DATA_W-1:0] DATA_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]        ELEM_LAST = 3'd5;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        elem;
    logic [2:0]        elem_nxt;
    logic              phase;
    logic              phase_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;

    logic              op_we;
    logic              op_ones;
    logic              two_op;
    logic              down;
    logic              down_next;
    logic              last_in_elem;
    logic              last_op;
    logic              start_run;
    logic              mismatch;
    logic              abort;
    logic              issue;

    logic              chk_valid;
    logic [DATA_W-1:0] chk_exp;
    logic [ADDR_W-1:0] chk_addr;
    logic [CNT_W-1:0]  fail_count;
    logic [ADDR_W-1:0] fail_addr;

    // op_ones is the data of the current op: write value or expected read value
    always_comb begin
        op_we   = 1'b0;
        op_ones = 1'b0;
        two_op  = 1'b1;
        down    = 1'b0;
        case (elem)
            3'd0: begin
                op_we  = 1'b1;
                two_op = 1'b0;
            end
            3'd1: begin
                op_we   = phase;
                op_ones = phase;
            end
            3'd2: begin
                op_we   = phase;
                op_ones = !phase;
            end
            3'd3: begin
                op_we   = phase;
                op_ones = phase;
                down    = 1'b1;
            end
            3'd4: begin
                op_we   = phase;
                op_ones = !phase;
                down    = 1'b1;
            end
            default: begin
                two_op = 1'b0;
            end
        endcase
    end

    // elements 3 and 4 walk downwards, so they start from the top address
    assign down_next    = (elem == 3'd2) || (elem == 3'd3);
    assign last_in_elem = down ? (addr == ADDR_ZERO) : (addr == ADDR_LAST);
    assign last_op      = (elem == ELEM_LAST) && last_in_elem;
    assign start_run    = ((state == IDLE) || (state == DONE)) && Start;
    assign mismatch     = chk_valid && (MemRdData != chk_exp);
    assign abort        = (STOP_ON_FAIL != 0) && mismatch;
    assign issue        = (state == RUN) && !abort;

    assign MemWe     = issue && op_we;
    assign MemRe     = issue && !op_we;
    assign MemAddr   = (state == RUN) ? addr : ADDR_ZERO;
    assign MemWrData = (MemWe && op_ones) ? DATA_ONES : DATA_ZERO;
    assign Busy      = (state == RUN) || (state == DRAIN);
    assign Done      = (state == DONE);
    assign GoNoGo    = Done && (fail_count == CNT_ZERO);
    assign FailAddr  = fail_addr;
    assign FailCount = fail_count;

    always_comb begin
        elem_nxt  = elem;
        phase_nxt = phase;
        addr_nxt  = addr;
        if (two_op && !phase) begin
            phase_nxt = 1'b1;
        end else begin
            phase_nxt = 1'b0;
            if (last_in_elem) begin
                elem_nxt = elem + 3'd1;
                addr_nxt = down_next ? ADDR_LAST : ADDR_ZERO;
            end else if (down) begin
                addr_nxt = addr - ADDR_ONE;
            end else begin
                addr_nxt = addr + ADDR_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort || last_op) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            elem       <= 3'd0;
            phase      <= 1'b0;
            addr       <= ADDR_ZERO;
            chk_valid  <= 1'b0;
            chk_exp    <= DATA_ZERO;
            chk_addr   <= ADDR_ZERO;
            fail_count <= CNT_ZERO;
            fail_addr  <= ADDR_ZERO;
        end else begin
            state <= state_nxt;
            if (start_run) begin
                elem       <= 3'd0;
                phase      <= 1'b0;
                addr       <= ADDR_ZERO;
                chk_valid  <= 1'b0;
                fail_count <= CNT_ZERO;
                fail_addr  <= ADDR_ZERO;
            end else begin
                if (state == RUN) begin
                    elem  <= elem_nxt;
                    phase <= phase_nxt;
                    addr  <= addr_nxt;
                end
                chk_valid <= MemRe;
                chk_exp   <= op_ones ? DATA_ONES : DATA_ZERO;
                chk_addr  <= addr;
                if (mismatch) begin
                    if (fail_count != CNT_MAX) begin
                        fail_count <= fail_count + CNT_ONE;
                    end
                    if (fail_count == CNT_ZERO) begin
                        fail_addr <= chk_addr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_march_cm_bist.sv
// Bench for march_cm_bist: March C- reference model plus directed scenarios.
module tb_march_cm_bist;

    localparam int AW      = 8;
    localparam int DW      = 4;
    localparam int N       = 256;
    localparam int OPS     = 10 * N;
    localparam int DONE_C  = OPS + 2;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;

    logic [AW-1:0] m_addr, s_addr, c_addr;
    logic [DW-1:0] m_wd, s_wd, c_wd;
    logic          m_we, s_we, c_we;
    logic          m_re, s_re, c_re;
    logic [DW-1:0] m_rd, s_rd, c_rd;
    logic          m_busy, s_busy, c_busy;
    logic          m_done, s_done, c_done;
    logic          m_go, s_go, c_go;
    logic [AW-1:0] m_faddr, s_faddr, c_faddr;
    logic [7:0]    m_fcnt, s_fcnt;
    logic [3:0]    c_fcnt;

    always #5 Clock = ~Clock;

    march_cm_bist dut (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .MemAddr(m_addr), .MemWrData(m_wd), .MemWe(m_we), .MemRe(m_re),
        .MemRdData(m_rd), .Busy(m_busy), .Done(m_done), .GoNoGo(m_go),
        .FailAddr(m_faddr), .FailCount(m_fcnt)
    );

    march_cm_bist #(.STOP_ON_FAIL(1)) dut_sf (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .MemAddr(s_addr), .MemWrData(s_wd), .MemWe(s_we), .MemRe(s_re),
        .MemRdData(s_rd), .Busy(s_busy), .Done(s_done), .GoNoGo(s_go),
        .FailAddr(s_faddr), .FailCount(s_fcnt)
    );

    march_cm_bist #(.CNT_W(4)) dut_c4 (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .MemAddr(c_addr), .MemWrData(c_wd), .MemWe(c_we), .MemRe(c_re),
        .MemRdData(c_rd), .Busy(c_busy), .Done(c_done), .GoNoGo(c_go),
        .FailAddr(c_faddr), .FailCount(c_fcnt)
    );

    // SRAM models; stuck-at-1 bits are ORed onto the read path
    logic [DW-1:0] mem_m [N];
    logic [DW-1:0] mem_s [N];
    logic [DW-1:0] mem_c [N];
    logic [AW-1:0] flt_addr;
    logic [DW-1:0] flt_mask;

    always @(posedge Clock) begin
        if (m_we) mem_m[m_addr] <= m_wd;
        if (m_re) m_rd <= mem_m[m_addr] | ((m_addr == flt_addr) ? flt_mask : '0);
    end

    always @(posedge Clock) begin
        if (s_we) mem_s[s_addr] <= s_wd;
        if (s_re) s_rd <= mem_s[s_addr] | ((s_addr == 8'h5A) ? 4'h4 : 4'h0);
    end

    always @(posedge Clock) begin
        if (c_we) mem_c[c_addr] <= c_wd;
        if (c_re) c_rd <= mem_c[c_addr] | 4'hF;
    end

    // reference model: the March C- op list and the reads that fail on it
    bit            op_is_w [OPS];
    logic [AW-1:0] op_a    [OPS];
    logic [DW-1:0] op_d    [OPS];
    int            pre     [OPS+1];
    int            first_fail;
    logic [DW-1:0] shadow  [N];
    int            m_cyc;

    int ncmp  = 0;
    int nfail = 0;
    int we_cnt = 0, re_cnt = 0, busy_cnt = 0;
    int s_strb = 0, s_bcnt = 0, c_bcnt = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add_op(inout int k, input bit w, input int a, input bit ones);
        op_is_w[k] = w;
        op_a[k]    = AW'(a);
        op_d[k]    = ones ? ONES : '0;
        k++;
    endtask

    task automatic build_ops();
        int k;
        int a;
        k = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (e == 3 || e == 4) ? N - 1 - i : i;
                if (e != 0) add_op(k, 1'b0, a, (e == 2 || e == 4));
                if (e != 5) add_op(k, 1'b1, a, (e == 1 || e == 3));
            end
        end
    endtask

    task automatic sim_faults();
        logic [DW-1:0] got;
        bit f;
        pre[0] = 0;
        first_fail = -1;
        for (int k = 0; k < OPS; k++) begin
            f = 1'b0;
            if (op_is_w[k]) begin
                shadow[op_a[k]] = op_d[k];
            end else begin
                got = shadow[op_a[k]] | ((op_a[k] == flt_addr) ? flt_mask : '0);
                f = (got != op_d[k]);
            end
            pre[k+1] = pre[k] + (f ? 1 : 0);
            if (f && first_fail < 0) first_fail = k;
        end
    endtask

    task automatic model_update();
        if (Reset) begin
            m_cyc = 0;
        end else if ((m_cyc == 0 || m_cyc == DONE_C) && Start) begin
            m_cyc = 1;
            sim_faults();
        end else if (m_cyc >= 1 && m_cyc < DONE_C) begin
            m_cyc++;
        end
    endtask

    task automatic compare();
        int c, idx, n;
        bit ew, er, eb, edn;
        logic [AW-1:0] ea, efa;
        logic [DW-1:0] ed;
        c = m_cyc;
        ew = 1'b0; er = 1'b0; ea = '0; ed = '0;
        if (c >= 1 && c <= OPS) begin
            ew = op_is_w[c-1];
            er = !ew;
            ea = op_a[c-1];
            ed = op_d[c-1];
        end
        eb  = (c >= 1 && c <= OPS + 1);
        edn = (c == DONE_C);
        idx = c - 2;
        if (idx < 0) idx = 0;
        if (idx > OPS) idx = OPS;
        n = (c == 0) ? 0 : pre[idx];
        if (n > 255) n = 255;
        efa = (c > 0 && first_fail >= 0 && first_fail + 3 <= c) ? op_a[first_fail] : '0;
        check("strobes", {m_we, m_re}, {ew, er});
        if (ew || er) check("addr", m_addr, ea);
        if (ew) check("wdata", m_wd, ed);
        check("busy_done_go", {m_busy, m_done, m_go}, {eb, edn, edn && (n == 0)});
        check("fcount", m_fcnt, n);
        check("faddr", m_faddr, efa);
        we_cnt   += m_we ? 1 : 0;
        re_cnt   += m_re ? 1 : 0;
        busy_cnt += m_busy ? 1 : 0;
        s_strb   += (s_we || s_re) ? 1 : 0;
        s_bcnt   += s_busy ? 1 : 0;
        c_bcnt   += c_busy ? 1 : 0;
    endtask

    task automatic step();
        @(posedge Clock);
        model_update();
        @(negedge Clock);
        compare();
    endtask

    task automatic wait_done(input int bound);
        int i;
        i = 0;
        while (!m_done && i < bound) begin
            step();
            i++;
        end
        check("done_within_bound", m_done, 1);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    int b0, w0, r0, sb0, ss0, cb0;

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        flt_addr = 8'h5A;
        flt_mask = 4'h0;
        m_cyc    = 0;
        first_fail = -1;
        for (int i = 0; i <= OPS; i++) pre[i] = 0;
        build_ops();

        #1;
        check("reset_outputs",
              {m_we, m_re, m_busy, m_done, m_go, m_addr, m_wd, m_fcnt, m_faddr}, 0);
        step();
        step();
        Reset = 1'b0;
        step();

        // fault-free run on the main DUT; faulty side DUTs run alongside
        b0 = busy_cnt; w0 = we_cnt; r0 = re_cnt;
        ss0 = s_strb; sb0 = s_bcnt; cb0 = c_bcnt;
        pulse_start();
        wait_done(3000);
        check("run1_busy_cycles", busy_cnt - b0, 2561);
        check("run1_we_count", we_cnt - w0, 1280);
        check("run1_re_count", re_cnt - r0, 1280);
        check("run1_gonogo", m_go, 1);
        check("run1_fcount", m_fcnt, 0);
        check("sf_done", s_done, 1);
        check("sf_gonogo", s_go, 0);
        check("sf_faddr", s_faddr, 8'h5A);
        check("sf_fcount", s_fcnt, 1);
        check("sf_busy_cycles", s_bcnt - sb0, 439);
        check("sf_strobes", s_strb - ss0, 437);
        check("c4_done", c_done, 1);
        check("c4_fcount_sat", c_fcnt, 15);
        check("c4_faddr", c_faddr, 0);
        check("c4_gonogo", c_go, 0);
        check("c4_busy_cycles", c_bcnt - cb0, 2561);

        // stuck-at-1 on bit 2 of 0x5A
        flt_mask = 4'h4;
        pulse_start();
        wait_done(3000);
        check("run2_fcount", m_fcnt, 3);
        check("run2_faddr", m_faddr, 8'h5A);
        check("run2_gonogo", m_go, 0);

        // reset in the middle of a run
        flt_mask = 4'h0;
        pulse_start();
        repeat (999) step();
        Reset = 1'b1;
        m_cyc = 0;
        #1;
        check("midreset_outputs",
              {m_we, m_re, m_busy, m_done, m_go, m_addr, m_wd, m_fcnt, m_faddr}, 0);
        w0 = we_cnt; r0 = re_cnt;
        step();
        step();
        check("midreset_no_strobes", (we_cnt - w0) + (re_cnt - r0), 0);
        Reset = 1'b0;
        step();
        b0 = busy_cnt;
        pulse_start();
        wait_done(3000);
        check("run3_busy_cycles", busy_cnt - b0, 2561);
        check("run3_gonogo", m_go, 1);

        // Start held high across a whole run and past Done
        flt_mask = 4'h4;
        Start = 1'b1;
        step();
        wait_done(3000);
        check("held_fcount_at_done", m_fcnt, 3);
        step();
        check("restart_busy", m_busy, 1);
        check("restart_done_clr", m_done, 0);
        check("restart_fcount_clr", m_fcnt, 0);
        repeat (500) step();
        Start = 1'b0;
        wait_done(3000);
        check("run5_fcount", m_fcnt, 3);
        check("run5_gonogo", m_go, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
